// File: rtl/fsm_stim_sequencer.sv
// fsm_stim_sequencer: queues run-length commands and drives them as a gap-free serial
// bit stream into the run-detector FSM, counting its out1/out2 responses.
`default_nettype none

module fsm_stim_sequencer #(
  parameter int LEN_W  = 8,
  parameter int DEPTH  = 4,
  parameter int STAT_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_bit_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              flush_i,
  input  logic              clear_stats_i,
  output logic              seq_in_o,
  output logic              seq_active_o,
  output logic              seq_done_o,
  input  logic              fsm_out1_i,
  input  logic              fsm_out2_i,
  output logic [STAT_W-1:0] cnt_out1_o,
  output logic [STAT_W-1:0] cnt_out2_o,
  output logic              err_zero_len_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Each entry holds {bit, len}; pointers carry one extra wrap bit for full/empty.
  logic [LEN_W:0]     mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;
  state_t             state_q;
  logic [LEN_W-1:0]   rem_q;
  logic               seq_in_q, seq_active_q, err_q;
  logic [STAT_W-1:0]  cnt1_q, cnt2_q;

  logic               w_empty, w_full, w_push, w_store, w_pop, w_last;
  logic [LEN_W:0]     w_head;

  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign w_push  = cmd_valid_i && !w_full && !flush_i;
  assign w_store = w_push && (cmd_len_i != '0);
  assign w_last  = (state_q == RUN) && (rem_q == LEN_W'(1));
  assign w_pop   = !flush_i && !w_empty && ((state_q == IDLE) || w_last);
  assign w_head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (w_store) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {cmd_bit_i, cmd_len_i};
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_store) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (w_pop)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Reload on the last bit of a run keeps back-to-back commands bubble-free.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      seq_in_q     <= 1'b0;
      seq_active_q <= 1'b0;
    end else if (flush_i) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      seq_in_q     <= 1'b0;
      seq_active_q <= 1'b0;
    end else if (w_pop) begin
      state_q      <= RUN;
      rem_q        <= w_head[LEN_W-1:0];
      seq_in_q     <= w_head[LEN_W];
      seq_active_q <= 1'b1;
    end else if (w_last) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      seq_in_q     <= 1'b0;
      seq_active_q <= 1'b0;
    end else if (state_q == RUN) begin
      rem_q        <= rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      err_q  <= 1'b0;
    end else if (clear_stats_i) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (fsm_out1_i && seq_active_q && (cnt1_q != '1)) cnt1_q <= cnt1_q + STAT_W'(1);
      if (fsm_out2_i && seq_active_q && (cnt2_q != '1)) cnt2_q <= cnt2_q + STAT_W'(1);
      if (w_push && (cmd_len_i == '0)) err_q <= 1'b1;
    end
  end

  assign cmd_ready_o    = !w_full;
  assign seq_in_o       = seq_in_q;
  assign seq_active_o   = seq_active_q;
  assign seq_done_o     = w_last && w_empty && !flush_i;
  assign cnt_out1_o     = cnt1_q;
  assign cnt_out2_o     = cnt2_q;
  assign err_zero_len_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_stim_sequencer.sv
// tb_fsm_stim_sequencer: directed self-checking bench for fsm_stim_sequencer.
`default_nettype none

module tb_fsm_stim_sequencer;

  localparam int LEN_W  = 8;
  localparam int DEPTH  = 4;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid, cmd_ready, cmd_bit;
  logic [LEN_W-1:0]  cmd_len;
  logic              flush, clear_stats;
  logic              seq_in, seq_active, seq_done;
  logic              fsm_out1, fsm_out2;
  logic [STAT_W-1:0] cnt_out1, cnt_out2;
  logic              err_zero_len;

  int chk_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // Stand-in detector: out2 follows the driven bit, out1 is bench-controlled.
  assign fsm_out2 = seq_in;

  fsm_stim_sequencer #(.LEN_W(LEN_W), .DEPTH(DEPTH), .STAT_W(STAT_W)) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_bit_i      (cmd_bit),
    .cmd_len_i      (cmd_len),
    .flush_i        (flush),
    .clear_stats_i  (clear_stats),
    .seq_in_o       (seq_in),
    .seq_active_o   (seq_active),
    .seq_done_o     (seq_done),
    .fsm_out1_i     (fsm_out1),
    .fsm_out2_i     (fsm_out2),
    .cnt_out1_o     (cnt_out1),
    .cnt_out2_o     (cnt_out2),
    .err_zero_len_o (err_zero_len)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic b, input logic [LEN_W-1:0] len);
    cmd_valid = 1'b1;
    cmd_bit   = b;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Offers cmds on consecutive cycles; sample k is taken just after edge k.
  logic             cb [8];
  logic [LEN_W-1:0] cl [8];
  logic [15:0]      act_v, in_v, done_v;

  task automatic run_seq(input int n_cmd, input int n_cyc);
    act_v = '0; in_v = '0; done_v = '0;
    for (int k = 0; k < n_cyc; k++) begin
      if (k < n_cmd) begin
        cmd_valid = 1'b1; cmd_bit = cb[k]; cmd_len = cl[k];
      end else begin
        cmd_valid = 1'b0;
      end
      tick();
      act_v[k]  = seq_active;
      in_v[k]   = seq_in;
      done_v[k] = seq_done;
    end
    cmd_valid = 1'b0;
  endtask

  logic [15:0] stream;
  int          nbits, refused, seen_active;
  logic        got_done, accept_now;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_bit = 1'b0; cmd_len = '0;
    flush = 1'b0; clear_stats = 1'b0; fsm_out1 = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_active", seq_active, 0);
    check("rst_in", seq_in, 0);
    check("rst_done", seq_done, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_cnt", {cnt_out1, cnt_out2}, 0);
    check("rst_err", err_zero_len, 0);

    // Single run (1,3) into idle
    cb[0] = 1'b1; cl[0] = 8'd3;
    run_seq(1, 5);
    check("t1_active", act_v[4:0], 5'b01110);
    check("t1_in", in_v[4:0], 5'b01110);
    check("t1_done", done_v[4:0], 5'b01000);
    check("t1_cnt2", cnt_out2, 3);

    // Back-to-back (1,2),(0,1),(1,4)
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    check("t2_clr", cnt_out2, 0);
    cb[0] = 1'b1; cl[0] = 8'd2;
    cb[1] = 1'b0; cl[1] = 8'd1;
    cb[2] = 1'b1; cl[2] = 8'd4;
    run_seq(3, 9);
    check("t2_active", act_v[8:0], 9'b011111110);
    check("t2_in", in_v[8:0], 9'b011110110);
    check("t2_done", done_v[8:0], 9'b010000000);
    check("t2_cnt2", cnt_out2, 6);

    // Fill the FIFO behind a running (1,6)
    push_cycle(1'b1, 8'd6);
    tick();
    push_cycle(1'b0, 8'd1);
    push_cycle(1'b1, 8'd2);
    push_cycle(1'b0, 8'd2);
    push_cycle(1'b1, 8'd1);
    check("t3_full_ready", cmd_ready, 0);
    check("t3_busy", seq_active, 1);
    cmd_valid = 1'b1; cmd_bit = 1'b0; cmd_len = 8'd3;
    stream = '0; nbits = 0; refused = 0; got_done = 1'b0;
    for (int i = 0; i < 40 && !got_done; i++) begin
      accept_now = cmd_valid && cmd_ready;
      if (cmd_valid && !cmd_ready) refused++;
      tick();
      if (accept_now) cmd_valid = 1'b0;
      if (seq_active) begin
        stream = {stream[14:0], seq_in};
        nbits++;
      end
      if (seq_done) got_done = 1'b1;
    end
    cmd_valid = 1'b0;
    check("t3_done_seen", got_done, 1);
    check("t3_refused", refused, 2);
    check("t3_nbits", nbits, 10);
    check("t3_stream", stream[9:0], 10'b1011001000);
    tick();
    check("t3_idle", seq_active, 0);

    // Zero-length command
    cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 8'd0;
    check("t4_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    check("t4_err", err_zero_len, 1);
    check("t4_ready_after", cmd_ready, 1);
    seen_active = 0;
    repeat (3) begin
      tick();
      if (seq_active) seen_active++;
    end
    check("t4_no_drive", seen_active, 0);
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    check("t4_err_clr", err_zero_len, 0);
    check("t4_cnt_clr", {cnt_out1, cnt_out2}, 0);

    // Flush on the 2nd bit of (1,5) with two commands queued
    push_cycle(1'b1, 8'd5);
    push_cycle(1'b0, 8'd3);
    push_cycle(1'b1, 8'd2);
    check("t5_pre_active", seq_active, 1);
    flush = 1'b1; cmd_valid = 1'b1; cmd_bit = 1'b1; cmd_len = 8'd1;
    tick();
    flush = 1'b0; cmd_valid = 1'b0;
    check("t5_active", seq_active, 0);
    check("t5_in", seq_in, 0);
    check("t5_done", seq_done, 0);
    check("t5_cnt2", cnt_out2, 2);
    check("t5_ready", cmd_ready, 1);
    seen_active = 0;
    repeat (4) begin
      tick();
      if (seq_active || seq_done) seen_active++;
    end
    check("t5_empty", seen_active, 0);

    // Saturation, clear priority, async reset mid-run
    fsm_out1 = 1'b1;
    push_cycle(1'b1, 8'd255);
    repeat (25) tick();
    check("t6_sat1", cnt_out1, 15);
    check("t6_sat2", cnt_out2, 15);
    tick();
    check("t6_hold1", cnt_out1, 15);
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    check("t6_clr_wins", cnt_out1, 0);
    tick();
    check("t6_recount", cnt_out1, 1);
    check("t6_running", seq_active, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_active", seq_active, 0);
    check("t6_rst_in", seq_in, 0);
    check("t6_rst_cnt", {cnt_out1, cnt_out2}, 0);
    check("t6_rst_ready", cmd_ready, 1);
    check("t6_rst_done", seq_done, 0);
    fsm_out1 = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
